// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 8-bit ALU behind a request/response valid-ready handshake, registered result and flags.
// Optional feature macro ALU_EXEC_MULTISHIFT_EN: LSH/RSH shift iteratively by InputB[2:0] instead of by 1.

module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [3:0]       OP,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Carry,
  output logic             IllegalOp
);

  typedef enum logic [3:0] {
    OP_LSH = 4'b0000,
    OP_RSH = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_GEQ = 4'b1000,
    OP_EQ  = 4'b1001,
    OP_NEG = 4'b1010,
    OP_ADD = 4'b1011,
    OP_NEQ = 4'b1101
  } op_e;

`ifdef ALU_EXEC_MULTISHIFT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_e;
`endif

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_carry;
  logic             r_illegal;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic             w_illegal;
  logic             w_accept;

`ifdef ALU_EXEC_MULTISHIFT_EN
  logic [2:0]       r_cnt;
  logic             r_left;
  logic             w_shift_go;
  logic [WIDTH-1:0] w_shift_step;

  assign w_shift_step = r_left ? {r_out[WIDTH-2:0], 1'b0} : {1'b0, r_out[WIDTH-1:1]};
`endif

  assign InReady  = (r_state == S_IDLE);
  assign OutValid = (r_state == S_DONE);
  assign w_accept = InValid & InReady;
  assign w_sum    = {1'b0, InputA} + {1'b0, InputB};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_result  = '0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
`ifdef ALU_EXEC_MULTISHIFT_EN
    w_shift_go = 1'b0;
`endif
    case (OP)
`ifdef ALU_EXEC_MULTISHIFT_EN
      // Shifts load A as the working value; SHIFT then steps it one bit per cycle.
      OP_LSH, OP_RSH: begin
        w_result   = InputA;
        w_shift_go = |InputB[2:0];
      end
`else
      OP_LSH: w_result = {InputA[WIDTH-2:0], 1'b0};
      OP_RSH: w_result = {1'b0, InputA[WIDTH-1:1]};
`endif
      OP_AND: w_result = InputA & InputB;
      OP_OR:  w_result = InputA | InputB;
      OP_GEQ: w_result = {{(WIDTH-1){1'b0}}, (InputA >= InputB)};
      OP_EQ:  w_result = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
      OP_NEQ: w_result = {{(WIDTH-1){1'b0}}, (InputA != InputB)};
      OP_NEG: w_result = ~InputA + 1'b1;
      OP_ADD: begin
        w_result = w_sum[WIDTH-1:0];
        w_carry  = w_sum[WIDTH];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef ALU_EXEC_MULTISHIFT_EN
          w_next = w_shift_go ? S_SHIFT : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef ALU_EXEC_MULTISHIFT_EN
      S_SHIFT: if (r_cnt == 3'd1) w_next = S_DONE;
`endif
      S_DONE:  if (OutReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: the async reset clears every datapath register so Out and flags are defined from reset on.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out     <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_EXEC_MULTISHIFT_EN
      r_cnt     <= 3'd0;
      r_left    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out     <= w_result;
            r_zero    <= (w_result == '0);
            r_carry   <= w_carry;
            r_illegal <= w_illegal;
`ifdef ALU_EXEC_MULTISHIFT_EN
            r_cnt     <= InputB[2:0];
            r_left    <= (OP == OP_LSH);
`endif
          end
        end
`ifdef ALU_EXEC_MULTISHIFT_EN
        S_SHIFT: begin
          r_out  <= w_shift_step;
          r_cnt  <= r_cnt - 3'd1;
          r_zero <= (w_shift_step == '0);
        end
`endif
        default: ;
      endcase
    end
  end

  assign Out       = r_out;
  assign Zero      = r_zero;
  assign Carry     = r_carry;
  assign IllegalOp = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; driver pushes expected responses, a negedge monitor pops and compares.
// Expected values come from an arithmetic reference model or directed constants.

module tb_alu_exec_unit;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       InValid;
  logic       InReady;
  logic [7:0] InputA;
  logic [7:0] InputB;
  logic [3:0] OP;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] Out;
  logic       Zero;
  logic       Carry;
  logic       IllegalOp;

  alu_exec_unit #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .InValid(InValid), .InReady(InReady),
    .InputA(InputA), .InputB(InputB), .OP(OP),
    .OutValid(OutValid), .OutReady(OutReady),
    .Out(Out), .Zero(Zero), .Carry(Carry), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int out;
    int zero;
    int carry;
    int illegal;
    int lat;
    int acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ready_mode = 1;  // 0 random, 1 always high, 2 always low

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input int out, input int zero, input int carry, input int illegal, input int lat);
    exp_t e;
    e.out = out; e.zero = zero; e.carry = carry; e.illegal = illegal; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Reference model from the operation rules, using integer arithmetic.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   amt;
    int   s;
`ifdef ALU_EXEC_MULTISHIFT_EN
    amt = b % 8;
`else
    amt = 1;
`endif
    e = mk(0, 0, 0, 0, 1);
    case (op)
      0:  begin e.out = (a * (1 << amt)) % 256; e.lat = (amt == 1 && op == 0) ? 1 : 1; end
      1:  e.out = a / (1 << amt);
      2:  e.out = a & b;
      3:  e.out = a | b;
      8:  e.out = (a >= b) ? 1 : 0;
      9:  e.out = (a == b) ? 1 : 0;
      10: e.out = (256 - a) % 256;
      11: begin s = a + b; e.out = s % 256; e.carry = (s >= 256) ? 1 : 0; end
      13: e.out = (a != b) ? 1 : 0;
      default: e.illegal = 1;
    endcase
`ifdef ALU_EXEC_MULTISHIFT_EN
    if (op == 0 || op == 1) e.lat = 1 + amt;
`endif
    e.zero = (e.out == 0) ? 1 : 0;
    return e;
  endfunction

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial begin
    OutReady = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      case (ready_mode)
        1:       OutReady = 1'b1;
        2:       OutReady = 1'b0;
        default: OutReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: latency at first OutValid, hold stability, and compare on handshake.
  initial begin
    logic       prev_valid;
    logic [7:0] h_out;
    logic [2:0] h_flags;
    exp_t       e;
    prev_valid = 1'b0;
    h_out = '0;
    h_flags = '0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        prev_valid = 1'b0;
      end else begin
        if (OutValid && !prev_valid) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got Out=0x%0h with no request outstanding (t=%0t)", Out, $time);
          end else begin
            check("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
          end
          h_out   = Out;
          h_flags = {Zero, Carry, IllegalOp};
        end else if (OutValid) begin
          check("hold_stable", int'({Out, Zero, Carry, IllegalOp}), int'({h_out, h_flags}));
        end
        if (OutValid && OutReady && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("out", int'(Out), e.out);
          check("zero", int'(Zero), e.zero);
          check("carry", int'(Carry), e.carry);
          check("illegal", int'(IllegalOp), e.illegal);
        end
        prev_valid = OutValid;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e, output int acc);
    int w;
    @(negedge Clk);
    InValid = 1'b1;
    OP      = op;
    InputA  = a;
    InputB  = b;
    w = 0;
    while (!InReady && w < 200) begin
      @(negedge Clk);
      w++;
    end
    if (!InReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: InReady stayed 0 for %0d cycles, required 1", w);
      InValid = 1'b0;
      acc = -1;
      return;
    end
    e.acc = cyc + 1;
    acc   = e.acc;
    sb_q.push_back(e);
    @(negedge Clk);
    InValid = 1'b0;
    InputA  = 8'($urandom_range(0, 255));
    InputB  = 8'($urandom_range(0, 255));
  endtask

  task automatic iss(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int acc;
    issue(op, a, b, e, acc);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((sb_q.size() != 0 || OutValid) && w < 300) begin
      @(negedge Clk);
      w++;
    end
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    int acc1;
    int acc2;
    int w;
    logic [3:0] r_op;
    Reset_n = 1'b0;
    InValid = 1'b0;
    InputA  = '0;
    InputB  = '0;
    OP      = '0;

    // Reset values
    repeat (3) @(negedge Clk);
    check("rst_inready", int'(InReady), 1);
    check("rst_outvalid", int'(OutValid), 0);
    check("rst_out", int'(Out), 0);
    check("rst_flags", int'({Zero, Carry, IllegalOp}), 0);
    Reset_n = 1'b1;

    // Reset while a long shift is in flight: response is discarded
    ready_mode = 2;
    issue(4'b0000, 8'h01, 8'h07, model(0, 1, 7), acc1);
    @(negedge Clk);
    Reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("rst_mid_outvalid", int'(OutValid), 0);
    check("rst_mid_inready", int'(InReady), 1);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (12) @(negedge Clk);
    check("no_resp_after_reset", int'(OutValid), 0);

    // Back-to-back ADD with OutReady held high
    ready_mode = 1;
    issue(4'b1011, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 1), acc1);
    issue(4'b1011, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 1), acc2);
    check("b2b_spacing", acc2 - acc1, 2);

    // Compare and logic ops
    iss(4'b1000, 8'd3, 8'd4, mk(8'h00, 1, 0, 0, 1));
    iss(4'b1001, 8'd2, 8'd2, mk(8'h01, 0, 0, 0, 1));
    iss(4'b1101, 8'd1, 8'd3, mk(8'h01, 0, 0, 0, 1));
    iss(4'b0011, 8'd1, 8'd0, mk(8'h01, 0, 0, 0, 1));
    iss(4'b0010, 8'd1, 8'd1, mk(8'h01, 0, 0, 0, 1));
    iss(4'b1010, 8'd1, 8'd0, mk(8'hFF, 0, 0, 0, 1));
    iss(4'b1010, 8'h80, 8'd0, mk(8'h80, 0, 0, 0, 1));
    iss(4'b1010, 8'h00, 8'd0, mk(8'h00, 1, 0, 0, 1));

    // Shifts
`ifdef ALU_EXEC_MULTISHIFT_EN
    iss(4'b0000, 8'h81, 8'h03, mk(8'h08, 0, 0, 0, 4));
    iss(4'b0001, 8'h81, 8'h00, mk(8'h81, 0, 0, 0, 1));
    iss(4'b0001, 8'h80, 8'h07, mk(8'h01, 0, 0, 0, 8));
    iss(4'b0000, 8'h80, 8'h01, mk(8'h00, 1, 0, 0, 2));
`else
    iss(4'b0000, 8'h81, 8'h03, mk(8'h02, 0, 0, 0, 1));
    iss(4'b0001, 8'h81, 8'h05, mk(8'h40, 0, 0, 0, 1));
    iss(4'b0000, 8'h80, 8'h00, mk(8'h00, 1, 0, 0, 1));
`endif
    wait_idle("drain_directed");

    // Backpressure: result held, no request accepted while OutReady is low
    ready_mode = 2;
    iss(4'b1011, 8'd5, 8'd6, mk(8'h0B, 0, 0, 0, 1));
    InValid = 1'b1;
    OP      = 4'b0010;
    InputA  = 8'hFF;
    InputB  = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      check("bp_inready", int'(InReady), 0);
      check("bp_out", int'(Out), 8'h0B);
      @(negedge Clk);
    end
    InValid = 1'b0;
    ready_mode = 1;
    w = 0;
    while (OutValid && w < 20) begin
      @(negedge Clk);
      w++;
    end
    check("bp_release_outvalid", int'(OutValid), 0);
    check("bp_release_inready", int'(InReady), 1);

    // Illegal opcode, then a legal op clears the flag
    iss(4'b0111, 8'h12, 8'h34, mk(8'h00, 1, 0, 1, 1));
    iss(4'b1011, 8'h12, 8'h34, mk(8'h46, 0, 0, 0, 1));
    wait_idle("drain_illegal");

    // Randomized traffic against the reference model with random backpressure
    ready_mode = 0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      r_op = 4'($urandom_range(0, 15));
      if (n % 5 == 0) rb = ra;
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      iss(r_op, ra, rb, model(int'(r_op), int'(ra), int'(rb)));
    end
    ready_mode = 1;
    wait_idle("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
